// File: rtl/dcache_responder.sv
// Memory-stage data responder: direct-mapped, write-through, no-write-allocate cache.
// Optional DCACHE_STATS_EN adds saturating hit/miss/store counters.
module dcache_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqM,
  input  logic                  memwriteM,
  input  logic [2:0]            funct3M,
  input  logic [ADDR_WIDTH-1:0] aluresultM,
  input  logic [DATA_WIDTH-1:0] writedataM,
  output logic [DATA_WIDTH-1:0] readdataM,
  output logic                  stallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_q [LINES];

  logic [INDEX_BITS-1:0]   idx_in, idx_tx;
  logic [TAG_W-1:0]        tag_in, tag_tx;
  logic                    hit_in, hit_tx;
  logic                    stall, fill_en, merge_en;
  logic                    hit_ev, miss_ev, wr_ev;
  logic [DATA_WIDTH-1:0]   rdata, merged;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'd0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign idx_in = aluresultM[INDEX_BITS+1:2];
  assign tag_in = aluresultM[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit_in = valid_q[idx_in] && (tag_q[idx_in] == tag_in);

  // The in-flight transaction is addressed from the latched request, not the live inputs.
  assign idx_tx = addr_q[INDEX_BITS+1:2];
  assign tag_tx = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit_tx = valid_q[idx_tx] && (tag_q[idx_tx] == tag_tx);

  always_comb begin
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : data_q[idx_tx][8*i +: 8];
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    stall    = 1'b0;
    rdata    = '0;
    fill_en  = 1'b0;
    merge_en = 1'b0;
    hit_ev   = 1'b0;
    miss_ev  = 1'b0;
    wr_ev    = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqM) begin
          if (memwriteM) begin
            stall   = 1'b1;
            state_d = WR_THRU;
            addr_d  = {aluresultM[ADDR_WIDTH-1:2], 2'b00};
            wr_ev   = 1'b1;
            case (funct3M)
              3'b000: begin
                wstrb_d = 4'b0001 << aluresultM[1:0];
                wdata_d = {4{writedataM[7:0]}};
              end
              3'b001: begin
                wstrb_d = aluresultM[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{writedataM[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = writedataM;
              end
            endcase
          end else if (hit_in) begin
            rdata  = fmt_load(funct3M, aluresultM[1:0], data_q[idx_in]);
            hit_ev = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = RD_MISS;
            addr_d  = {aluresultM[ADDR_WIDTH-1:2], 2'b00};
            wstrb_d = 4'b0000;
            miss_ev = 1'b1;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ack) begin
          stall   = 1'b0;
          fill_en = 1'b1;
          // Pipeline holds its inputs while stalled, so the live funct3/offset still apply.
          rdata   = fmt_load(funct3M, aluresultM[1:0], mem_rdata);
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        stall = 1'b1;
        if (mem_ack) begin
          stall    = 1'b0;
          merge_en = hit_tx;
          wstrb_d  = 4'b0000;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so a held reqM cannot raise a stall.
  assign stallM    = rst & stall;
  assign readdataM = rst ? rdata : '0;
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == WR_THRU);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (fill_en) valid_q[idx_tx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx_tx]  <= tag_tx;
      data_q[idx_tx] <= mem_rdata;
    end else if (merge_en) begin
      data_q[idx_tx] <= merged;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d, wr_q, wr_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    wr_d   = wr_q;
    if (hit_ev  && hit_q  != '1) hit_d  = hit_q  + 32'd1;
    if (miss_ev && miss_q != '1) miss_d = miss_q + 32'd1;
    if (wr_ev   && wr_q   != '1) wr_d   = wr_q   + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      wr_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      wr_q   <= wr_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wr_count   = wr_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: misses, hits, load formatting, write-through, eviction, reset abort.
module tb_dcache_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqM = 1'b0, memwriteM = 1'b0;
  logic [2:0]  funct3M = 3'b010;
  logic [31:0] aluresultM = '0, writedataM = '0;
  logic [31:0] readdataM;
  logic        stallM, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wr_count;
`endif

  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk(clk), .rst(rst), .reqM(reqM), .memwriteM(memwriteM), .funct3M(funct3M),
    .aluresultM(aluresultM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wr_count(wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    reqM = 1'b1; memwriteM = we; funct3M = f3; aluresultM = a; writedataM = wd;
  endtask

  task automatic load_hit(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(1'b0, f3, a, 32'd0);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(stallM), 32'd0);
    chk({tag, "_data"}, readdataM, exp);
  endtask

  task automatic load_miss(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input int dly, input logic [31:0] rdat, input logic [31:0] exp);
    int stalls;
    stalls = 0;
    drive(1'b0, f3, a, 32'd0);
    @(negedge clk);
    chk({tag, "_stall_req"}, 32'(stallM), 32'd1);
    chk({tag, "_memreq_req"}, 32'(mem_req), 32'd0);
    stalls += int'(stallM);
    repeat (dly) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
      chk({tag, "_memwe"}, 32'(mem_we), 32'd0);
      chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
      stalls += int'(stallM);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = rdat;
    @(negedge clk);
    chk({tag, "_stall_ack"}, 32'(stallM), 32'd0);
    chk({tag, "_data"}, readdataM, exp);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(dly + 1));
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; reqM = 1'b0;
    @(negedge clk);
    chk({tag, "_memreq_done"}, 32'(mem_req), 32'd0);
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata);
    drive(1'b1, f3, a, wd);
    @(negedge clk);
    chk({tag, "_stall_req"}, 32'(stallM), 32'd1);
    repeat (dly) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
      chk({tag, "_memwe"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
      chk({tag, "_strb"}, 32'(mem_wstrb), 32'(exp_strb));
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_stall"}, 32'(stallM), 32'd1);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk({tag, "_stall_ack"}, 32'(stallM), 32'd0);
    chk({tag, "_memreq_ack"}, 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0; reqM = 1'b0;
    @(negedge clk);
    chk({tag, "_memreq_done"}, 32'(mem_req), 32'd0);
    chk({tag, "_memwe_done"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_memwe", 32'(mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    #1 rst = 1'b1;

    // Cold miss with 3 wait cycles, then hit.
    load_miss("lw100_miss", 3'b010, 32'h100, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    load_hit("lw100_hit", 3'b010, 32'h100, 32'hDEADBEEF);

    // Store hit overwrites whole word; then load formatting, back to back.
    store("sw100", 3'b010, 32'h100, 32'h80FF7F01, 1, 4'b1111, 32'h80FF7F01);
    load_hit("lw100_new", 3'b010, 32'h100, 32'h80FF7F01);
    load_hit("lb103", 3'b000, 32'h103, 32'hFFFFFF80);
    load_hit("lbu103", 3'b100, 32'h103, 32'h00000080);
    load_hit("lh102", 3'b001, 32'h102, 32'hFFFF80FF);
    load_hit("lhu100", 3'b101, 32'h100, 32'h00007F01);
    load_hit("lhu101", 3'b101, 32'h101, 32'h00007F01);
    load_hit("lb100", 3'b000, 32'h100, 32'h00000001);

    // Byte store merges into the cached line.
    store("sb101", 3'b000, 32'h101, 32'h000000AB, 2, 4'b0010, 32'hABABABAB);
    load_hit("lw100_merged", 3'b010, 32'h100, 32'h80FFAB01);

    // Half store to an uncached address on the same index must not touch the line.
    store("sh302", 3'b001, 32'h302, 32'h00001234, 1, 4'b1100, 32'h12341234);
    load_hit("lw100_after_sh", 3'b010, 32'h100, 32'h80FFAB01);

    // Store miss does not allocate; load then evicts 0x100; 0x100 refetches.
    store("sw200", 3'b010, 32'h200, 32'h55AA55AA, 1, 4'b1111, 32'h55AA55AA);
    load_miss("lw200_miss", 3'b010, 32'h200, 2, 32'h55AA55AA, 32'h55AA55AA);
    load_hit("lw200_hit", 3'b010, 32'h200, 32'h55AA55AA);
    load_miss("lw100_evicted", 3'b010, 32'h100, 1, 32'h80FFAB01, 32'h80FFAB01);
    load_hit("lw100_f3_undef", 3'b011, 32'h100, 32'h80FFAB01);
    load_hit("lhu102_b2b", 3'b101, 32'h102, 32'h000080FF);

    // Stray ack in IDLE is ignored.
    @(posedge clk); #1;
    reqM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("idle_ack_memreq", 32'(mem_req), 32'd0);
    chk("idle_ack_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    load_hit("lw100_after_stray", 3'b010, 32'h100, 32'h80FFAB01);

    // Reset in the middle of a read miss.
    drive(1'b0, 3'b010, 32'h204, 32'd0);
    @(negedge clk);
    chk("abort_stall_req", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_memreq_pre", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_memreq", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stallM), 32'd0);
    chk("abort_memwe", 32'(mem_we), 32'd0);
    chk("abort_rdata", readdataM, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; reqM = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("late_ack_memreq", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    load_miss("lw204_after_rst", 3'b010, 32'h204, 1, 32'h13579BDF, 32'h13579BDF);
    load_miss("lw100_after_rst", 3'b010, 32'h100, 1, 32'h80FFAB01, 32'h80FFAB01);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
